sensor_packet_controller: RTL and testbench

- Parametrised next-generation sensor node controller.
- Buffers sensor samples into external single-port memory, used as a ring buffer.
- Once PKT_LEN samples are buffered, builds a framed packet and streams it byte-wise to the radio under a busy handshake: sequence-number header, payload, checksum.
- Sits between the sensor front-end, sample memory and radio transmitter.

---
 rtl/sensor_packet_controller.sv | 160 ++++++++++++++++
 tb/tb_sensor_packet_controller.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_packet_controller.sv
// sensor_packet_controller: ring-buffers sensor samples in external memory
// and streams framed packets (seq header, payload, checksum) to a radio.
module sensor_packet_controller #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 6,
  parameter int PKT_LEN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] sensor_data,
  input  logic              sensor_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              radio_busy,
  output logic              radio_send,
  output logic [DATA_W-1:0] radio_data,
  output logic              tx_active,
  output logic              overflow,
  output logic [15:0]       drop_count
);
  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] DEPTH = CW'(2 ** ADDR_W);
  localparam logic [CW-1:0] PLEN = CW'(PKT_LEN);

  typedef enum logic [2:0] {
    IDLE, HDR, RD, RDWAIT, DATA, CSUM
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     sent_q, sent_d;
  logic [DATA_W-1:0] seq_q, seq_d;
  logic [DATA_W-1:0] csum_q, csum_d;
  logic [DATA_W-1:0] byte_q, byte_d;
  logic              ovf_q, ovf_d;
  logic [15:0]       drop_q, drop_d;
  logic              full, smp, wr, pay_acc;

  // Writes are gated by rst_n so the memory port is quiet during reset.
  assign full = (count_q == DEPTH);
  assign smp  = rst_n && enable && sensor_valid;
  assign wr   = smp && !full;

  assign mem_we     = wr;
  assign mem_wdata  = wr ? sensor_data : '0;
  assign mem_addr   = wr ? wr_ptr_q : (mem_re ? rd_ptr_q : '0);
  assign tx_active  = (state_q != IDLE);
  assign overflow   = ovf_q;
  assign drop_count = drop_q;

  // Sample path: write pointer advance and drop accounting.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;
    if (wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (smp && full) begin
      ovf_d = 1'b1;
      if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end
  end

  // Occupancy: +1 per write, -1 per accepted payload byte.
  always_comb begin
    count_d = count_q + {{ADDR_W{1'b0}}, wr}
                      - {{ADDR_W{1'b0}}, pay_acc};
  end

  // Transmit FSM next-state and radio/read outputs.
  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    sent_d     = sent_q;
    seq_d      = seq_q;
    csum_d     = csum_q;
    byte_d     = byte_q;
    radio_send = 1'b0;
    radio_data = '0;
    mem_re     = 1'b0;
    pay_acc    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable && count_q >= PLEN) state_d = HDR;
      end
      HDR: begin
        radio_send = 1'b1;
        radio_data = seq_q;
        if (!radio_busy) begin
          csum_d  = seq_q;
          sent_d  = '0;
          state_d = RD;
        end
      end
      RD: begin
        if (!wr) begin
          mem_re  = 1'b1;
          state_d = RDWAIT;
        end
      end
      RDWAIT: begin
        byte_d  = mem_rdata;
        state_d = DATA;
      end
      DATA: begin
        radio_send = 1'b1;
        radio_data = byte_q;
        if (!radio_busy) begin
          pay_acc  = 1'b1;
          csum_d   = csum_q + byte_q;
          rd_ptr_d = rd_ptr_q + 1'b1;
          sent_d   = sent_q + 1'b1;
          state_d  = ((sent_q + 1'b1) == PLEN) ? CSUM : RD;
        end
      end
      CSUM: begin
        radio_send = 1'b1;
        radio_data = '0 - csum_q;
        if (!radio_busy) begin
          seq_d   = seq_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sent_q   <= '0;
      seq_q    <= '0;
      csum_q   <= '0;
      byte_q   <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sent_q   <= sent_d;
      seq_q    <= seq_d;
      csum_q   <= csum_d;
      byte_q   <= byte_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

endmodule

// File: tb/tb_sensor_packet_controller.sv
// tb_sensor_packet_controller: scoreboard bench with a packet-level
// reference model; a negedge monitor checks every radio byte.
module tb_sensor_packet_controller;
  localparam int AW = 6;
  localparam int PL = 4;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          enable = 1'b0;
  logic          sensor_valid = 1'b0;
  logic [7:0]    sensor_data = 8'h00;
  logic          radio_busy = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata, mem_rdata;
  logic          mem_we, mem_re;
  logic          radio_send, tx_active, overflow;
  logic [7:0]    radio_data;
  logic [15:0]   drop_count;

  sensor_packet_controller #(
    .DATA_W(8), .ADDR_W(AW), .PKT_LEN(PL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .sensor_data(sensor_data), .sensor_valid(sensor_valid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .radio_busy(radio_busy), .radio_send(radio_send),
    .radio_data(radio_data), .tx_active(tx_active),
    .overflow(overflow), .drop_count(drop_count)
  );

  // Small instance: 4-deep buffer, radio permanently busy.
  logic        en2 = 1'b0;
  logic        sv2 = 1'b0;
  logic [7:0]  sd2 = 8'h00;
  logic [1:0]  ma2;
  logic [7:0]  mw2, rdat2;
  logic        we2, re2, rs2, ta2, ov2;
  logic [15:0] dc2;

  sensor_packet_controller #(
    .DATA_W(8), .ADDR_W(2), .PKT_LEN(4)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(en2),
    .sensor_data(sd2), .sensor_valid(sv2),
    .mem_addr(ma2), .mem_wdata(mw2),
    .mem_we(we2), .mem_re(re2), .mem_rdata(8'h00),
    .radio_busy(1'b1), .radio_send(rs2),
    .radio_data(rdat2), .tx_active(ta2),
    .overflow(ov2), .drop_count(dc2)
  );

  // Single-port memory, read data one cycle after mem_re.
  logic [7:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference model: samples queue up; every PL samples make a packet.
  typedef struct {
    logic [7:0] b;
    bit         pay;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] pend[$];
  logic [7:0] seq_m = 8'h00;
  int         acc = 0;
  int         pay_acc = 0;
  int         drops_m = 0;

  function automatic void build_pkt();
    logic [7:0] s;
    logic [7:0] d;
    s = seq_m;
    expq.push_back('{b: seq_m, pay: 1'b0});
    while (pend.size() != 0) begin
      d = pend.pop_front();
      s = s + d;
      expq.push_back('{b: d, pay: 1'b1});
    end
    expq.push_back('{b: 8'h00 - s, pay: 1'b0});
    seq_m = seq_m + 8'h01;
  endfunction

  function automatic void model_reset();
    expq.delete();
    pend.delete();
    seq_m = 8'h00;
    acc = 0;
    pay_acc = 0;
    drops_m = 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [7:0] d);
    sensor_data = d;
    sensor_valid = 1'b1;
    if (enable) begin
      if (acc - pay_acc < DEPTH) begin
        acc++;
        pend.push_back(d);
        if (pend.size() == PL) build_pkt();
      end else begin
        drops_m++;
      end
    end
    tick();
    sensor_valid = 1'b0;
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_re"}, mem_re, 0);
    chk({tag, "_radio_send"}, radio_send, 0);
    chk({tag, "_radio_data"}, radio_data, 0);
    chk({tag, "_tx_active"}, tx_active, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_drop_count"}, drop_count, 0);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (expq.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_left", expq.size(), 0);
    tick();
    tick();
    chk("tx_idle", tx_active, 0);
  endtask

  // Monitor: radio bytes vs scoreboard, hold-while-busy, port exclusion.
  bit         prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;
  exp_t       e;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_send", radio_send, 1);
        chk("hold_data", radio_data, prev_data);
      end
      if (mem_we || mem_re) chk("we_re_excl", mem_we && mem_re, 0);
      if (radio_send && !radio_busy) begin
        if (expq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_byte: got %0h expected none", radio_data);
        end else begin
          e = expq.pop_front();
          chk("radio_byte", radio_data, e.b);
          if (e.pay) pay_acc++;
        end
      end
      prev_hold = radio_send && radio_busy;
      prev_data = radio_data;
    end
  end

  // Write addresses seen on the small instance.
  int w2q[$];
  always @(negedge clk) begin
    if (rst_n && we2) w2q.push_back(int'(ma2));
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    // Small buffer: 6 samples, 4 stored, 2 dropped.
    en2 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sd2 = 8'(i + 1);
      sv2 = 1'b1;
      tick();
      sv2 = 1'b0;
    end
    tick();
    chk("small_writes", w2q.size(), 4);
    for (int i = 0; i < w2q.size() && i < 4; i++)
      chk("small_wr_addr", w2q[i], i);
    chk("small_overflow", ov2, 1);
    chk("small_drops", dc2, 2);
    chk("small_wr_ptr", dut2.wr_ptr_q, 0);
    chk("small_hdr_send", rs2, 1);
    chk("small_hdr_data", rdat2, 0);

    // Disabled: samples neither written nor counted as drops.
    for (int i = 0; i < 3; i++) begin
      sensor_data = 8'hEE;
      sensor_valid = 1'b1;
      #1;
      chk("disabled_we", mem_we, 0);
      tick();
      sensor_valid = 1'b0;
    end
    chk("disabled_drops", drop_count, 0);

    // Packet 1: seq 0, 0x10..0x40, checksum 0x60.
    enable = 1'b1;
    radio_busy = 1'b0;
    for (int i = 1; i <= 4; i++) sample(8'(i * 16));
    wait_drain(200);

    // Packet 2 with the header held off by busy for 5 cycles.
    radio_busy = 1'b1;
    for (int i = 1; i <= 4; i++) sample(8'(i));
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("busy_hdr_send", radio_send, 1);
      chk("busy_hdr_data", radio_data, 8'h01);
      tick();
    end
    radio_busy = 1'b0;
    wait_drain(200);

    // Random traffic with random radio back-pressure.
    for (int c = 0; c < 1500; c++) begin
      radio_busy = ($urandom_range(9) < 3);
      if ($urandom_range(7) == 0) sample(8'($urandom));
      else tick();
    end
    radio_busy = 1'b0;
    wait_drain(1000);
    chk("no_overflow", overflow, 0);
    chk("drops_match", drop_count, drops_m);

    // Reset in the middle of a payload byte.
    for (int i = 0; i < 4; i++) sample(8'hA0 + 8'(i));
    n = 0;
    while (!mem_re && n < 100) begin
      tick();
      n++;
    end
    chk("reached_rd", mem_re, 1);
    radio_busy = 1'b1;
    tick();
    tick();
    chk("in_data_send", radio_send, 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_zero("mid_reset");
    tick();
    rst_n = 1'b1;
    radio_busy = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) sample(8'h55 + 8'(i));
    wait_drain(200);

    chk("final_queue", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
